// File: rtl/cpu86_retire_checker_if.sv
// cpu86_retire_checker_if
//   One retire-record stream with valid/ready handshake. A record transfers
//   on a rising clk edge where valid && ready.
//   valid  : record present          ready  : sink can accept
//   cs, ip : address of the retired instruction
//   regs   : post-execution registers, index i at [i*DATA_W +: DATA_W]
//   mask   : per-register compare enable (DUT stream only)
//   branch : record is a control transfer (DUT stream only)
//   master/slave carry the full DUT stream; gold_master/gold_slave carry the
//   reference stream, which has no mask or branch.
interface cpu86_retire_checker_if #(
    parameter int DATA_W = 16,
    parameter int NREG   = 13
);
    logic                   valid;
    logic                   ready;
    logic [DATA_W-1:0]      cs;
    logic [DATA_W-1:0]      ip;
    logic [NREG*DATA_W-1:0] regs;
    logic [NREG-1:0]        mask;
    logic                   branch;

    modport master      (output valid, cs, ip, regs, mask, branch, input ready);
    modport slave       (input  valid, cs, ip, regs, mask, branch, output ready);
    modport gold_master (output valid, cs, ip, regs, input ready);
    modport gold_slave  (input  valid, cs, ip, regs, output ready);
endinterface

// File: rtl/cpu86_retire_checker.sv
// cpu86_retire_checker
//   Lock-step checker comparing a DUT retire stream against a golden-model
//   stream. Each stream is buffered in its own DEPTH-entry FIFO; head pairs
//   are compared one per cycle. After a DUT control transfer the checker
//   enters RESYNC and may discard up to MAX_SKIP wrong-path DUT records
//   while looking for the reference address.
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   dut_if          : DUT stream (slave)
//   ref_if          : reference stream (gold_slave)
//   err_valid       : one-cycle error pulse, 1 cycle after the pop
//   err_code        : 1 CS:IP mismatch, 2 register mismatch, 3 resync fail
//   err_reg         : per-register mismatch flags (code 2 only)
//   err_cnt, chk_cnt, skip_cnt_total : saturating statistics
//   halt            : sticky, set once err_cnt reaches ERR_LIMIT

// Per-register comparator; CMP_MASK selects which bits participate.
module cpu86_retire_reg_cmp #(
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] CMP_MASK = '1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              en,
    output logic              miss
);
    assign miss = en && (|((a ^ b) & CMP_MASK));
endmodule

module cpu86_retire_checker #(
    parameter int                DATA_W    = 16,
    parameter int                NREG      = 13,
    parameter int                DEPTH     = 8,
    parameter logic [DATA_W-1:0] FL_MASK   = 16'h0FD5,
    parameter int                MAX_SKIP  = 4,
    parameter int                ERR_LIMIT = 100
) (
    input  logic                         clk,
    input  logic                         reset,
    cpu86_retire_checker_if.slave        dut_if,
    cpu86_retire_checker_if.gold_slave   ref_if,
    output logic                         err_valid,
    output logic [1:0]                   err_code,
    output logic [NREG-1:0]              err_reg,
    output logic [31:0]                  err_cnt,
    output logic [31:0]                  chk_cnt,
    output logic [31:0]                  skip_cnt_total,
    output logic                         halt
);
    localparam int AW  = $clog2(DEPTH);
    localparam int SW  = (MAX_SKIP < 1) ? 1 : $clog2(MAX_SKIP + 1);
    localparam int RW  = NREG * DATA_W;
    localparam int DRW = 2 * DATA_W + RW + NREG + 1;   // {branch, mask, regs, ip, cs}
    localparam int GRW = 2 * DATA_W + RW;              // {regs, ip, cs}

    localparam logic [SW-1:0] SKIP_MAX = SW'(MAX_SKIP);
    localparam logic [31:0]   ERR_LIM  = 32'(ERR_LIMIT);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_RESYNC = 1'b1;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // ---------------- input FIFOs ----------------
    // Pointers carry one extra wrap bit so full/empty need no counter.
    logic [DRW-1:0] d_mem [DEPTH];
    logic [GRW-1:0] g_mem [DEPTH];
    logic [AW:0]    d_wr, d_rd, g_wr, g_rd;
    logic [AW:0]    d_occ, g_occ;
    logic           d_full, g_full, d_empty, g_empty;
    logic           d_push, g_push, d_pop, g_pop;

    assign d_occ   = d_wr - d_rd;
    assign g_occ   = g_wr - g_rd;
    assign d_full  = d_occ[AW];
    assign g_full  = g_occ[AW];
    assign d_empty = (d_wr == d_rd);
    assign g_empty = (g_wr == g_rd);

    assign dut_if.ready = !d_full;
    assign ref_if.ready = !g_full;
    assign d_push = dut_if.valid && !d_full;
    assign g_push = ref_if.valid && !g_full;

    always_ff @(posedge clk) begin
        if (d_push) d_mem[d_wr[AW-1:0]] <= {dut_if.branch, dut_if.mask, dut_if.regs,
                                            dut_if.ip, dut_if.cs};
        if (g_push) g_mem[g_wr[AW-1:0]] <= {ref_if.regs, ref_if.ip, ref_if.cs};
    end

    // ---------------- head decode ----------------
    logic [DRW-1:0]    d_head;
    logic [GRW-1:0]    g_head;
    logic [DATA_W-1:0] d_cs, d_ip, g_cs, g_ip;
    logic [RW-1:0]     d_regs, g_regs;
    logic [NREG-1:0]   d_mask;
    logic              d_branch;

    assign d_head   = d_mem[d_rd[AW-1:0]];
    assign g_head   = g_mem[g_rd[AW-1:0]];
    assign d_cs     = d_head[0 +: DATA_W];
    assign d_ip     = d_head[DATA_W +: DATA_W];
    assign d_regs   = d_head[2*DATA_W +: RW];
    assign d_mask   = d_head[2*DATA_W + RW +: NREG];
    assign d_branch = d_head[DRW-1];
    assign g_cs     = g_head[0 +: DATA_W];
    assign g_ip     = g_head[DATA_W +: DATA_W];
    assign g_regs   = g_head[2*DATA_W +: RW];

    // FL (last index) compares only the architecturally defined flag bits.
    logic [NREG-1:0] reg_miss;
    for (genvar g = 0; g < NREG; g++) begin : g_cmp
        localparam logic [DATA_W-1:0] CMASK = (g == NREG - 1) ? FL_MASK : {DATA_W{1'b1}};
        cpu86_retire_reg_cmp #(.DATA_W(DATA_W), .CMP_MASK(CMASK)) u_cmp (
            .a    (d_regs[g*DATA_W +: DATA_W]),
            .b    (g_regs[g*DATA_W +: DATA_W]),
            .en   (d_mask[g]),
            .miss (reg_miss[g])
        );
    end

    // ---------------- control ----------------
    logic [0:0]      state, state_n;
    logic [SW-1:0]   skip_q, skip_n;
    logic            stall, heads, addr_eq, cmp_ev, skip_ev;
    logic [1:0]      code_n;
    logic [NREG-1:0] reg_n;

    // Stall as soon as the limit is reached so no record slips in during
    // the cycle before halt registers.
    assign stall   = halt || (err_cnt >= ERR_LIM);
    assign heads   = !d_empty && !g_empty && !stall;
    assign addr_eq = (d_cs == g_cs) && (d_ip == g_ip);

    always_comb begin
        state_n = state;
        skip_n  = skip_q;
        d_pop   = 1'b0;
        g_pop   = 1'b0;
        cmp_ev  = 1'b0;
        skip_ev = 1'b0;
        code_n  = 2'd0;
        if (heads) begin
            if (state == ST_RUN || addr_eq) begin
                d_pop   = 1'b1;
                g_pop   = 1'b1;
                cmp_ev  = 1'b1;
                skip_n  = '0;
                code_n  = !addr_eq   ? 2'd1 :
                          |reg_miss  ? 2'd2 : 2'd0;
                state_n = d_branch ? ST_RESYNC : ST_RUN;
            end else if (skip_q < SKIP_MAX) begin
                // Wrong-path DUT record after a branch: drop it quietly.
                d_pop   = 1'b1;
                skip_ev = 1'b1;
                skip_n  = skip_q + SW'(1);
            end else begin
                d_pop   = 1'b1;
                g_pop   = 1'b1;
                cmp_ev  = 1'b1;
                skip_n  = '0;
                code_n  = 2'd3;
                state_n = ST_RUN;
            end
        end
        reg_n = (code_n == 2'd2) ? reg_miss : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_wr           <= '0;
            d_rd           <= '0;
            g_wr           <= '0;
            g_rd           <= '0;
            state          <= ST_RUN;
            skip_q         <= '0;
            err_valid      <= 1'b0;
            err_code       <= 2'd0;
            err_reg        <= '0;
            err_cnt        <= '0;
            chk_cnt        <= '0;
            skip_cnt_total <= '0;
            halt           <= 1'b0;
        end else begin
            d_wr      <= d_wr + (AW+1)'(d_push);
            g_wr      <= g_wr + (AW+1)'(g_push);
            d_rd      <= d_rd + (AW+1)'(d_pop);
            g_rd      <= g_rd + (AW+1)'(g_pop);
            state     <= state_n;
            skip_q    <= skip_n;
            err_valid <= (code_n != 2'd0);
            err_code  <= code_n;
            err_reg   <= reg_n;
            if (cmp_ev)           chk_cnt        <= sat_inc(chk_cnt);
            if (code_n != 2'd0)   err_cnt        <= sat_inc(err_cnt);
            if (skip_ev)          skip_cnt_total <= sat_inc(skip_cnt_total);
            if (err_cnt >= ERR_LIM) halt         <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cpu86_retire_checker.sv
// tb_cpu86_retire_checker
//   Directed bench for cpu86_retire_checker (ERR_LIMIT=2 so halt is
//   reachable; reset separates the scenarios).
module tb_cpu86_retire_checker;
    localparam int DW = 16;
    localparam int NR = 13;

    logic            clk = 1'b0;
    logic            reset;
    logic            err_valid;
    logic [1:0]      err_code;
    logic [NR-1:0]   err_reg;
    logic [31:0]     err_cnt, chk_cnt, skip_cnt_total;
    logic            halt;

    always #5 clk = ~clk;

    cpu86_retire_checker_if #(.DATA_W(DW), .NREG(NR)) dut_bus ();
    cpu86_retire_checker_if #(.DATA_W(DW), .NREG(NR)) ref_bus ();

    cpu86_retire_checker #(
        .DATA_W(DW), .NREG(NR), .DEPTH(8), .FL_MASK(16'h0FD5),
        .MAX_SKIP(4), .ERR_LIMIT(2)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .dut_if         (dut_bus),
        .ref_if         (ref_bus),
        .err_valid      (err_valid),
        .err_code       (err_code),
        .err_reg        (err_reg),
        .err_cnt        (err_cnt),
        .chk_cnt        (chk_cnt),
        .skip_cnt_total (skip_cnt_total),
        .halt           (halt)
    );

    int checks   = 0;
    int failures = 0;
    int err_seen = 0;
    int s0;
    logic [1:0]    last_code = 2'd0;
    logic [NR-1:0] last_reg  = '0;

    // Capture error pulses for scenarios where the exact cycle is not probed.
    always @(negedge clk) begin
        if (err_valid) begin
            err_seen++;
            last_code = err_code;
            last_reg  = err_reg;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NR*DW-1:0] mk_regs(input logic [15:0] ax, input logic [15:0] fl);
        logic [NR*DW-1:0] r;
        for (int i = 0; i < NR; i++) r[i*DW +: DW] = 16'(16'h1000 + i);
        r[0 +: DW]         = ax;
        r[(NR-1)*DW +: DW] = fl;
        return r;
    endfunction

    task automatic put_dut(input logic [15:0] cs, input logic [15:0] ip,
                           input logic [NR*DW-1:0] regs, input logic [NR-1:0] mask,
                           input logic br);
        dut_bus.valid  = 1'b1;
        dut_bus.cs     = cs;
        dut_bus.ip     = ip;
        dut_bus.regs   = regs;
        dut_bus.mask   = mask;
        dut_bus.branch = br;
    endtask

    task automatic put_ref(input logic [15:0] cs, input logic [15:0] ip,
                           input logic [NR*DW-1:0] regs);
        ref_bus.valid = 1'b1;
        ref_bus.cs    = cs;
        ref_bus.ip    = ip;
        ref_bus.regs  = regs;
    endtask

    task automatic clear();
        dut_bus.valid = 1'b0;
        ref_bus.valid = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear();
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_dut_ready"}, dut_bus.ready, 1);
        chk({tag, "_ref_ready"}, ref_bus.ready, 1);
        chk({tag, "_err_valid"}, err_valid, 0);
        chk({tag, "_err_code"},  err_code, 0);
        chk({tag, "_err_reg"},   err_reg, 0);
        chk({tag, "_err_cnt"},   err_cnt, 0);
        chk({tag, "_chk_cnt"},   chk_cnt, 0);
        chk({tag, "_skip_tot"},  skip_cnt_total, 0);
        chk({tag, "_halt"},      halt, 0);
    endtask

    initial begin
        reset = 1'b1;
        dut_bus.valid = 1'b0; dut_bus.cs = '0; dut_bus.ip = '0; dut_bus.regs = '0;
        dut_bus.mask = '0; dut_bus.branch = 1'b0;
        ref_bus.valid = 1'b0; ref_bus.cs = '0; ref_bus.ip = '0; ref_bus.regs = '0;
        ref_bus.mask = '0; ref_bus.branch = 1'b0;
        tick();
        tick();
        chk_reset_state("por");
        reset = 1'b0;

        // ---- 10 matching records ----
        s0 = err_seen;
        for (int i = 0; i < 10; i++) begin
            put_dut(16'h0000, 16'(16'h0100 + i), mk_regs(16'(16'h2000 + i), 16'h0046), '1, 1'b0);
            put_ref(16'h0000, 16'(16'h0100 + i), mk_regs(16'(16'h2000 + i), 16'h0046));
            tick();
        end
        clear();
        repeat (3) tick();
        chk("match_chk_cnt", chk_cnt, 10);
        chk("match_err_cnt", err_cnt, 0);
        chk("match_no_err",  err_seen - s0, 0);

        // ---- AX mismatch, exact latency ----
        apply_reset();
        put_dut(16'h0000, 16'h0100, mk_regs(16'h1234, 16'h0000), 13'h0001, 1'b0);
        put_ref(16'h0000, 16'h0100, mk_regs(16'h1235, 16'h0000));
        tick();                       // pushed
        clear();
        chk("ax_pre_valid", err_valid, 0);
        tick();                       // popped and compared
        chk("ax_valid", err_valid, 1);
        chk("ax_code",  err_code, 2);
        chk("ax_reg",   err_reg, 13'h0001);
        tick();
        chk("ax_pulse_end", err_valid, 0);
        chk("ax_err_cnt",   err_cnt, 1);
        chk("ax_chk_cnt",   chk_cnt, 1);

        // FL bit 1 is outside FL_MASK -> no error
        put_dut(16'h0000, 16'h0101, mk_regs(16'h0055, 16'h0002), '1, 1'b0);
        put_ref(16'h0000, 16'h0101, mk_regs(16'h0055, 16'h0000));
        tick();
        clear();
        tick();
        chk("fl_masked_valid", err_valid, 0);
        tick();

        // FL CF differs -> register error on FL only
        put_dut(16'h0000, 16'h0102, mk_regs(16'h0055, 16'h0001), '1, 1'b0);
        put_ref(16'h0000, 16'h0102, mk_regs(16'h0055, 16'h0000));
        tick();
        clear();
        tick();
        chk("fl_cf_valid", err_valid, 1);
        chk("fl_cf_code",  err_code, 2);
        chk("fl_cf_reg",   err_reg, 13'h1000);
        tick();

        // CS:IP mismatch suppresses register compare
        apply_reset();
        put_dut(16'h0000, 16'h0105, mk_regs(16'h0001, 16'h0000), '1, 1'b0);
        put_ref(16'h0000, 16'h0104, mk_regs(16'h0002, 16'h0000));
        tick();
        clear();
        tick();
        chk("addr_valid", err_valid, 1);
        chk("addr_code",  err_code, 1);
        chk("addr_reg",   err_reg, 0);
        tick();

        // ---- branch, two wrong-path skips, resync ----
        apply_reset();
        s0 = err_seen;
        put_dut(16'h0000, 16'h0100, mk_regs(16'h0007, 16'h0000), '1, 1'b1);
        put_ref(16'h0000, 16'h0100, mk_regs(16'h0007, 16'h0000));
        tick();
        put_dut(16'h0000, 16'h0200, mk_regs(16'h0007, 16'h0000), '1, 1'b0);
        put_ref(16'h0000, 16'h0300, mk_regs(16'h0008, 16'h0000));
        tick();
        ref_bus.valid = 1'b0;
        put_dut(16'h0000, 16'h0202, mk_regs(16'h0007, 16'h0000), '1, 1'b0);
        tick();
        put_dut(16'h0000, 16'h0300, mk_regs(16'h0008, 16'h0000), '1, 1'b0);
        tick();
        clear();
        repeat (3) tick();
        chk("resync_skip_tot", skip_cnt_total, 2);
        chk("resync_chk_cnt",  chk_cnt, 2);
        chk("resync_no_err",   err_seen - s0, 0);
        // Back in RUN: an address mismatch is an error, not a skip.
        put_dut(16'h0000, 16'h0400, mk_regs(16'h0000, 16'h0000), '1, 1'b0);
        put_ref(16'h0000, 16'h0401, mk_regs(16'h0000, 16'h0000));
        tick();
        clear();
        tick();
        chk("run_again_valid", err_valid, 1);
        chk("run_again_code",  err_code, 1);
        tick();
        chk("run_again_skip_tot", skip_cnt_total, 2);

        // ---- resync failure after MAX_SKIP skips ----
        apply_reset();
        s0 = err_seen;
        put_dut(16'h0000, 16'h0100, mk_regs(16'h0000, 16'h0000), '1, 1'b1);
        put_ref(16'h0000, 16'h0100, mk_regs(16'h0000, 16'h0000));
        tick();
        put_dut(16'h0000, 16'h0600, mk_regs(16'h0000, 16'h0000), '1, 1'b0);
        put_ref(16'h0000, 16'h0500, mk_regs(16'h0000, 16'h0000));
        tick();
        ref_bus.valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            put_dut(16'h0000, 16'(16'h0600 + i), mk_regs(16'h0000, 16'h0000), '1, 1'b0);
            tick();
        end
        clear();
        repeat (6) tick();
        chk("rsfail_seen",     err_seen - s0, 1);
        chk("rsfail_code",     last_code, 3);
        chk("rsfail_reg",      last_reg, 0);
        chk("rsfail_skip_tot", skip_cnt_total, 4);
        chk("rsfail_chk_cnt",  chk_cnt, 2);
        // Both heads were consumed: a fresh matching pair compares clean.
        put_dut(16'h0000, 16'h0700, mk_regs(16'h0000, 16'h0000), '1, 1'b0);
        put_ref(16'h0000, 16'h0700, mk_regs(16'h0000, 16'h0000));
        tick();
        clear();
        repeat (2) tick();
        chk("rsfail_after_seen", err_seen - s0, 1);
        chk("rsfail_after_chk",  chk_cnt, 3);

        // ---- halt at ERR_LIMIT=2 ----
        apply_reset();
        s0 = err_seen;
        for (int i = 0; i < 3; i++) begin
            put_dut(16'h0000, 16'(16'h0100 + i), mk_regs(16'h0010, 16'h0000), 13'h0001, 1'b0);
            put_ref(16'h0000, 16'(16'h0100 + i), mk_regs(16'h0011, 16'h0000));
            tick();
        end
        clear();
        repeat (2) tick();
        chk("halt_set",     halt, 1);
        chk("halt_err_cnt", err_cnt, 2);
        chk("halt_chk_cnt", chk_cnt, 2);
        chk("halt_seen",    err_seen - s0, 2);
        put_ref(16'h0000, 16'h0900, mk_regs(16'h0000, 16'h0000));
        repeat (6) tick();
        chk("halt_ref_ready_7", ref_bus.ready, 1);
        tick();
        chk("halt_ref_ready_full", ref_bus.ready, 0);
        chk("halt_dut_ready",      dut_bus.ready, 1);
        tick();
        chk("halt_no_pop_chk", chk_cnt, 2);
        clear();
        reset = 1'b1;
        tick();
        chk_reset_state("halt_rst");
        reset = 1'b0;
        tick();

        // ---- DUT FIFO fills while ref is stalled, then reset ----
        put_dut(16'h0000, 16'h0100, mk_regs(16'h0000, 16'h0000), '1, 1'b0);
        repeat (7) tick();
        chk("fill_dut_ready_7", dut_bus.ready, 1);
        tick();
        chk("fill_dut_ready_full", dut_bus.ready, 0);
        chk("fill_ref_ready",      ref_bus.ready, 1);
        chk("fill_chk_cnt",        chk_cnt, 0);
        reset = 1'b1;
        tick();
        chk_reset_state("fill_rst");
        reset = 1'b0;
        clear();
        tick();
        chk("fill_post_ready", dut_bus.ready, 1);

        // ---- reset discards a pending compare ----
        put_dut(16'h0000, 16'h0100, mk_regs(16'h0001, 16'h0000), '1, 1'b0);
        put_ref(16'h0000, 16'h0100, mk_regs(16'h0002, 16'h0000));
        tick();
        clear();
        reset = 1'b1;
        tick();
        chk("midrst_valid", err_valid, 0);
        chk("midrst_chk",   chk_cnt, 0);
        reset = 1'b0;
        tick();
        chk("midrst_valid_after", err_valid, 0);
        tick();
        chk("midrst_err_cnt", err_cnt, 0);
        chk("midrst_chk_cnt", chk_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu86_retire_checker.md
CPU86_RETIRE_CHECKER -- requirements
Module: cpu86_retire_checker

Interface
REQ-001 Parameter DATA_W, default 16: width of CS, IP and each register field.
REQ-002 Parameter NREG, default 13: registers per record, index order AX,DX,CX,BX,BP,SI,DI,SP,ES,CS,SS,DS,FL; FL is always index NREG-1.
REQ-003 Parameter DEPTH, default 8, power of two >=2: entries in each input FIFO.
REQ-004 Parameter FL_MASK, default 16'h0FD5: compared FL bits (CF,PF,AF,ZF,SF,TF,IF,DF,OF).
REQ-005 Parameter MAX_SKIP, default 4: DUT records discardable per resync.
REQ-006 Parameter ERR_LIMIT, default 100: error count that asserts halt.
REQ-007 Port clk, input, 1: single clock; all logic on rising edge.
REQ-008 Port reset, input, 1: synchronous, active-high reset.
REQ-009 Ports dut_valid/dut_ready, input/output, 1 each: DUT retire stream handshake; transfer when both high.
REQ-010 Ports dut_cs, dut_ip, input, DATA_W each: address of the retired instruction.
REQ-011 Port dut_regs, input, NREG*DATA_W: post-execution registers, index i at bits [i*DATA_W +: DATA_W].
REQ-012 Port dut_mask, input, NREG: per-register compare enable for this record.
REQ-013 Port dut_branch, input, 1: record is a control transfer; successor may be mispredicted.
REQ-014 Ports ref_valid/ref_ready, ref_cs, ref_ip, ref_regs: golden-model stream, same widths and handshake as the DUT stream.
REQ-015 Ports err_valid (1), err_code (2), err_reg (NREG), output: one-cycle error report.
REQ-016 Ports err_cnt, chk_cnt, skip_cnt_total, output, 32 each: saturating statistics.
REQ-017 Port halt, output, 1: sticky, err_cnt >= ERR_LIMIT.

Function
REQ-018 Each stream SHALL enter its own DEPTH-entry FIFO; x_ready = !full; no record is ever dropped at input.
REQ-019 A push and pop on the same FIFO in the same cycle SHALL both take effect; occupancy unchanged; pointers wrap modulo DEPTH.
REQ-020 FSM states RUN and RESYNC; reset state RUN.
REQ-021 RUN, both heads valid, halt low: pop both heads in the same cycle and compare (a compare event).
REQ-022 Compare: CS:IP differ -> err_code 1; else any i with dut_mask[i] and field mismatch -> err_code 2, err_reg[i]=1 for every such i; FL compares only FL_MASK bits.
REQ-023 CS:IP error SHALL set err_reg to 0 and suppress register comparison for that record.
REQ-024 Compare result SHALL be registered: err_valid/err_code/err_reg appear exactly 1 cycle after the pop; err_valid high for one cycle only on error.
REQ-025 chk_cnt SHALL increment once per compare event; err_cnt once per err_valid pulse.
REQ-026 A compare event whose DUT record has dut_branch=1 SHALL move the FSM to RESYNC (also from RESYNC), skip counter cleared.
REQ-027 RESYNC, both heads valid: DUT CS:IP equal to ref CS:IP -> normal compare event, next state per REQ-026 else RUN.
REQ-028 RESYNC, CS:IP differ, skip counter < MAX_SKIP -> pop DUT head only, no error, skip counter and skip_cnt_total +1.
REQ-029 RESYNC, CS:IP differ, skip counter == MAX_SKIP -> compare event reporting err_code 3 (resync fail), pop both, next state RUN.
REQ-030 err_code 0 SHALL never be reported with err_valid high.
REQ-031 halt SHALL assert the cycle after err_cnt reaches ERR_LIMIT; while halt, no pops; FIFOs fill and ready drops.
REQ-032 All 32-bit counters SHALL saturate at all-ones.
REQ-033 Only one head pair per cycle is consumed; throughput 1 compare/cycle.

Reset
REQ-034 reset SHALL empty both FIFOs, set state RUN, clear skip counter, and drive err_valid=0, err_code=0, err_reg=0, all counters 0, halt=0, dut_ready=ref_ready=1 the cycle after.
REQ-035 reset mid-operation SHALL discard FIFO contents and any pending err report; no err_valid in the cycle after reset.

Verification
REQ-036 10 matching records CS:IP 0000:0100..0109, all masks 1 -> chk_cnt=10, err_cnt=0, no err_valid.
REQ-037 Record DUT AX=0x1234, ref AX=0x1235, mask AX only -> err_valid 1 cycle after pop, err_code 2, err_reg bit0 only; DUT FL=0x0002 vs ref FL=0x0000 with FL masked -> no error.
REQ-038 Branch record, then DUT 0000:0200, 0000:0202, then 0000:0300 matching ref 0000:0300 -> skip_cnt_total=2, no error, FSM back to RUN.
REQ-039 Branch record, then 5 DUT records none matching ref head, MAX_SKIP=4 -> 4 skipped, fifth yields err_code 3, both popped.
REQ-040 ERR_LIMIT=2, three mismatching records -> halt after second err_valid, third not compared, ref_valid held high with no pops until FIFO full then ref_ready=0.
REQ-041 ref stalled, DUT pushes DEPTH records -> dut_ready=0 after DEPTH pushes; assert reset -> all outputs per REQ-034 next cycle.
